// File: rtl/wb_reg_file_if.sv
// Bundles the write-back, reservation and operand-read signals of the
// register file. The master side (write-back/decode) drives the requests;
// the slave side (the register file) returns operands and hazard status.
interface wb_reg_file_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic                   wb_en;
  logic [ADDR_W-1:0]      wb_addr;
  logic [DATA_W-1:0]      wb_data;
  logic                   rsv_en;
  logic [ADDR_W-1:0]      rsv_addr;
  logic [ADDR_W-1:0]      rd_a_addr;
  logic [ADDR_W-1:0]      rd_b_addr;
  logic                   rd_a_use;
  logic                   rd_b_use;
  logic [DATA_W-1:0]      rd_a_data;
  logic [DATA_W-1:0]      rd_b_data;
  logic                   rd_a_busy;
  logic                   rd_b_busy;
  logic                   stall;
  logic [(1<<ADDR_W)-1:0] busy_vec;

  modport master (
    output wb_en, wb_addr, wb_data, rsv_en, rsv_addr,
           rd_a_addr, rd_b_addr, rd_a_use, rd_b_use,
    input  rd_a_data, rd_b_data, rd_a_busy, rd_b_busy, stall, busy_vec
  );

  modport slave (
    input  wb_en, wb_addr, wb_data, rsv_en, rsv_addr,
           rd_a_addr, rd_b_addr, rd_a_use, rd_b_use,
    output rd_a_data, rd_b_data, rd_a_busy, rd_b_busy, stall, busy_vec
  );
endinterface

// File: rtl/wb_reg_file.sv
// Architectural register file with write-through bypass and a per-register
// busy scoreboard. Write-back releases a destination, decode reserves one,
// and a stall is raised when a needed operand is still pending.
module wb_reg_file #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int R0_ZERO = 1
) (
  input  logic            clk,
  input  logic            rst,
  wb_reg_file_if.slave    bus
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;

  // Address 0 is the hardwired-zero register when R0_ZERO is enabled.
  function automatic logic is_r0(input logic [ADDR_W-1:0] addr);
    return (R0_ZERO != 0) && (addr == '0);
  endfunction

  // A same-cycle write-back to this address is visible through the bypass.
  function automatic logic wb_hit(input logic                en,
                                  input logic [ADDR_W-1:0]   waddr,
                                  input logic [ADDR_W-1:0]   raddr);
    return en && (waddr == raddr) && !is_r0(raddr);
  endfunction

  // Scoreboard next state: release on write-back, then reserve so a new
  // producer to the same register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (bus.wb_en)
      busy_d[bus.wb_addr] = 1'b0;
    if (bus.rsv_en)
      busy_d[bus.rsv_addr] = 1'b1;
    if (R0_ZERO != 0)
      busy_d[0] = 1'b0;
  end

  // Scoreboard state; reset discards any pending reservation.
  always_ff @(posedge clk) begin
    if (rst)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  // Register storage; writes to the hardwired zero register are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= '0;
    end else if (bus.wb_en && !is_r0(bus.wb_addr)) begin
      regs_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Operand read with bypass, and hazard detection per read port.
  always_comb begin
    bus.rd_a_data = regs_q[bus.rd_a_addr];
    bus.rd_b_data = regs_q[bus.rd_b_addr];
    if (wb_hit(bus.wb_en, bus.wb_addr, bus.rd_a_addr))
      bus.rd_a_data = bus.wb_data;
    if (wb_hit(bus.wb_en, bus.wb_addr, bus.rd_b_addr))
      bus.rd_b_data = bus.wb_data;
    if (is_r0(bus.rd_a_addr))
      bus.rd_a_data = '0;
    if (is_r0(bus.rd_b_addr))
      bus.rd_b_data = '0;

    bus.rd_a_busy = busy_q[bus.rd_a_addr] &&
                    !(bus.wb_en && (bus.wb_addr == bus.rd_a_addr));
    bus.rd_b_busy = busy_q[bus.rd_b_addr] &&
                    !(bus.wb_en && (bus.wb_addr == bus.rd_b_addr));
    bus.stall     = (bus.rd_a_use && bus.rd_a_busy) ||
                    (bus.rd_b_use && bus.rd_b_busy);
  end

  assign bus.busy_vec = busy_q;

endmodule

// File: tb/tb_wb_reg_file.sv
// Directed-vector bench for wb_reg_file: the stimulus process pushes the
// hand-computed expected response of each vector into a queue and a
// separate monitor pops and compares it on the falling edge.
module tb_wb_reg_file;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  wb_reg_file_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  wb_reg_file #(.DATA_W(16), .ADDR_W(3), .R0_ZERO(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    string       nm;
    logic [15:0] ad;
    logic [15:0] bd;
    logic        ab;
    logic        bb;
    logic        st;
    logic [7:0]  bv;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Monitor: one expected response per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      bit   bad;
      e   = q.pop_front();
      bad = 1'b0;
      vectors++;
      if (bus.rd_a_data !== e.ad) begin
        $display("FAIL %s rd_a_data got %h want %h", e.nm, bus.rd_a_data, e.ad); bad = 1'b1;
      end
      if (bus.rd_b_data !== e.bd) begin
        $display("FAIL %s rd_b_data got %h want %h", e.nm, bus.rd_b_data, e.bd); bad = 1'b1;
      end
      if (bus.rd_a_busy !== e.ab) begin
        $display("FAIL %s rd_a_busy got %b want %b", e.nm, bus.rd_a_busy, e.ab); bad = 1'b1;
      end
      if (bus.rd_b_busy !== e.bb) begin
        $display("FAIL %s rd_b_busy got %b want %b", e.nm, bus.rd_b_busy, e.bb); bad = 1'b1;
      end
      if (bus.stall !== e.st) begin
        $display("FAIL %s stall got %b want %b", e.nm, bus.stall, e.st); bad = 1'b1;
      end
      if (bus.busy_vec !== e.bv) begin
        $display("FAIL %s busy_vec got %h want %h", e.nm, bus.busy_vec, e.bv); bad = 1'b1;
      end
      if (bad)
        miscompares++;
    end
  end

  task automatic vec(
    input string nm, input logic r,
    input logic we, input logic [2:0] wa, input logic [15:0] wd,
    input logic re, input logic [2:0] rsa,
    input logic [2:0] ra, input logic [2:0] rb, input logic ua, input logic ub,
    input logic [15:0] ad, input logic [15:0] bd,
    input logic ab, input logic bb, input logic st, input logic [7:0] bv);
    exp_t e;
    @(posedge clk);
    #1;
    rst           = r;
    bus.wb_en     = we;
    bus.wb_addr   = wa;
    bus.wb_data   = wd;
    bus.rsv_en    = re;
    bus.rsv_addr  = rsa;
    bus.rd_a_addr = ra;
    bus.rd_b_addr = rb;
    bus.rd_a_use  = ua;
    bus.rd_b_use  = ub;
    e.nm = nm; e.ad = ad; e.bd = bd; e.ab = ab; e.bb = bb; e.st = st; e.bv = bv;
    q.push_back(e);
  endtask

  initial begin
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.rsv_en = 1'b0; bus.rsv_addr = '0;
    bus.rd_a_addr = '0; bus.rd_b_addr = '0;
    bus.rd_a_use = 1'b0; bus.rd_b_use = 1'b0;
    @(posedge clk);
    //   name         rst we wa   wd       re rsa  ra   rb   ua ub  a_data   b_data   ab bb st busy
    vec("reset_rd",   0, 0, 3'd0, 16'h0000, 0, 3'd0, 3'd3, 3'd5, 1, 1, 16'h0000, 16'h0000, 0, 0, 0, 8'h00);
    vec("wr_bypass",  0, 1, 3'd2, 16'h3AED, 0, 3'd0, 3'd2, 3'd5, 1, 0, 16'h3AED, 16'h0000, 0, 0, 0, 8'h00);
    vec("wr_stored",  0, 0, 3'd0, 16'h0000, 0, 3'd0, 3'd2, 3'd2, 1, 1, 16'h3AED, 16'h3AED, 0, 0, 0, 8'h00);
    vec("rsv_r4",     0, 0, 3'd0, 16'h0000, 1, 3'd4, 3'd2, 3'd4, 1, 1, 16'h3AED, 16'h0000, 0, 0, 0, 8'h00);
    vec("stall_r4",   0, 0, 3'd0, 16'h0000, 0, 3'd0, 3'd2, 3'd4, 1, 1, 16'h3AED, 16'h0000, 0, 1, 1, 8'h10);
    vec("release_r4", 0, 1, 3'd4, 16'h07E0, 0, 3'd0, 3'd2, 3'd4, 1, 1, 16'h3AED, 16'h07E0, 0, 0, 0, 8'h10);
    vec("after_rel4", 0, 0, 3'd0, 16'h0000, 0, 3'd0, 3'd2, 3'd4, 1, 1, 16'h3AED, 16'h07E0, 0, 0, 0, 8'h00);
    vec("rsv_r5",     0, 0, 3'd0, 16'h0000, 1, 3'd5, 3'd4, 3'd2, 1, 1, 16'h07E0, 16'h3AED, 0, 0, 0, 8'h00);
    vec("busy_nouse", 0, 0, 3'd0, 16'h0000, 0, 3'd0, 3'd5, 3'd5, 0, 0, 16'h0000, 16'h0000, 1, 1, 0, 8'h20);
    vec("stall_a_r5", 0, 0, 3'd0, 16'h0000, 0, 3'd0, 3'd5, 3'd2, 1, 0, 16'h0000, 16'h3AED, 1, 0, 1, 8'h20);
    vec("rsv_wb_r6",  0, 1, 3'd6, 16'h1E0F, 1, 3'd6, 3'd6, 3'd5, 0, 0, 16'h1E0F, 16'h0000, 0, 1, 0, 8'h20);
    vec("r6_owned",   0, 0, 3'd0, 16'h0000, 0, 3'd0, 3'd6, 3'd5, 1, 0, 16'h1E0F, 16'h0000, 1, 1, 1, 8'h60);
    vec("release_r5", 0, 1, 3'd5, 16'hA5A5, 0, 3'd0, 3'd5, 3'd6, 1, 0, 16'hA5A5, 16'h1E0F, 0, 1, 0, 8'h60);
    vec("release_r6", 0, 1, 3'd6, 16'h5A5A, 0, 3'd0, 3'd6, 3'd5, 1, 1, 16'h5A5A, 16'hA5A5, 0, 0, 0, 8'h40);
    vec("r0_wr_rsv",  0, 1, 3'd0, 16'hFFFF, 1, 3'd0, 3'd0, 3'd0, 1, 1, 16'h0000, 16'h0000, 0, 0, 0, 8'h00);
    vec("r0_after",   0, 0, 3'd0, 16'h0000, 0, 3'd0, 3'd0, 3'd7, 1, 1, 16'h0000, 16'h0000, 0, 0, 0, 8'h00);
    vec("wr_r7",      0, 1, 3'd7, 16'h8001, 0, 3'd0, 3'd7, 3'd6, 1, 1, 16'h8001, 16'h5A5A, 0, 0, 0, 8'h00);
    vec("rd_r7",      0, 0, 3'd0, 16'h0000, 0, 3'd0, 3'd7, 3'd1, 1, 1, 16'h8001, 16'h0000, 0, 0, 0, 8'h00);
    vec("wr_r1",      0, 1, 3'd1, 16'h15F3, 0, 3'd0, 3'd1, 3'd7, 0, 0, 16'h15F3, 16'h8001, 0, 0, 0, 8'h00);
    vec("rsv_r1",     0, 0, 3'd0, 16'h0000, 1, 3'd1, 3'd1, 3'd1, 1, 0, 16'h15F3, 16'h15F3, 0, 0, 0, 8'h00);
    vec("rst_mid",    1, 1, 3'd1, 16'h3333, 1, 3'd3, 3'd1, 3'd3, 1, 1, 16'h3333, 16'h0000, 0, 0, 0, 8'h02);
    vec("after_rst",  0, 0, 3'd0, 16'h0000, 0, 3'd0, 3'd1, 3'd7, 1, 1, 16'h0000, 16'h0000, 0, 0, 0, 8'h00);
    vec("after_rst2", 0, 0, 3'd0, 16'h0000, 0, 3'd0, 3'd6, 3'd2, 1, 1, 16'h0000, 16'h0000, 0, 0, 0, 8'h00);

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(posedge clk);
    if (q.size() > 0) begin
      $display("FAIL drain pending %0d want 0", q.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_reg_file.md
Name: wb_reg_file

Overview:
- Architectural register file that consumes the write-back stage result (selected ALU-buffer or data-memory word plus its write-back control).
- Supplies two read operands to the decode stage.
- Holds a per-register busy scoreboard: decode reserves a destination, write-back releases it, and a hazard/stall indication is produced.
- Sits between the write-back mux output and the decode/operand-fetch stage of the 16-bit pipeline.

Parameters:
- DATA_W, 16, width of each register and of the write-back data.
- ADDR_W, 3, register address width; the file holds 2**ADDR_W registers.
- R0_ZERO, 1, when 1, register 0 reads as zero, ignores writes and is never busy.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- wb_en  input  1  write-back enable (write-back control from the MEM/WB buffer).
- wb_addr  input  ADDR_W  destination register of the write-back.
- wb_data  input  DATA_W  write-back value (output of the write-back mux).
- rsv_en  input  1  decode reserves a destination register for an issued instruction.
- rsv_addr  input  ADDR_W  register being reserved.
- rd_a_addr  input  ADDR_W  read port A address.
- rd_b_addr  input  ADDR_W  read port B address.
- rd_a_use  input  1  port A operand is actually needed.
- rd_b_use  input  1  port B operand is actually needed.
- rd_a_data  output  DATA_W  port A operand.
- rd_b_data  output  DATA_W  port B operand.
- rd_a_busy  output  1  port A register has a pending, not-yet-bypassable write.
- rd_b_busy  output  1  port B register has a pending, not-yet-bypassable write.
- stall  output  1  decode must hold this cycle.
- busy_vec  output  2**ADDR_W  current scoreboard bits, for debug and verification.

Behaviour:
- Reset (rst=1 at a clk edge):
  - all registers clear to 0 and all busy bits clear to 0;
  - rst dominates wb_en and rsv_en in the same cycle;
  - a reservation pending when reset is asserted is discarded.
- After reset, with no writes, rd_a_data=rd_b_data=0, busy outputs=0 and stall=0.
- Write: on the rising edge with rst=0 and wb_en=1, reg[wb_addr] <= wb_data. There is one write per cycle. If R0_ZERO=1 and wb_addr=0, the write is dropped.
- Read: combinational, zero-cycle latency.
  - rd_x_data = wb_data when wb_en=1, wb_addr==rd_x_addr and the address is not the R0 hardwired case (write-through bypass, so same-cycle write-back is visible).
  - Otherwise rd_x_data = reg[rd_x_addr].
  - With R0_ZERO=1, address 0 always reads 0.
- Scoreboard, on the rising edge with rst=0:
  - wb_en=1 clears busy[wb_addr];
  - rsv_en=1 sets busy[rsv_addr];
  - when both target the same address in the same cycle, set wins: the new producer owns the register;
  - with R0_ZERO=1, busy[0] is never set.
- Hazard (combinational):
  - rd_x_busy = busy[rd_x_addr] AND NOT (wb_en AND wb_addr==rd_x_addr). A same-cycle write-back resolves the hazard through the bypass.
  - stall = (rd_a_use AND rd_a_busy) OR (rd_b_use AND rd_b_busy).
  - rsv_en is expected to be low while stall=1, and the block does not gate it.
- Width rules:
  - no arithmetic is performed; data is stored and returned unmodified at DATA_W bits;
  - addresses index all 2**ADDR_W entries with no wrap or aliasing.
- Both read ports may address the same register; both return identical data and busy.

Test Plan:
- Reset then read: after rst held 2 cycles, read r3/r5 -> rd_a_data=0x0000, rd_b_data=0x0000, busy_vec=8'h00, stall=0.
- Write then read: wb_en=1, wb_addr=2, wb_data=0x3AED -> same cycle rd_a_addr=2 returns 0x3AED (bypass); next cycle with wb_en=0 it still returns 0x3AED from storage.
- Reserve/stall/release:
  - rsv_en=1, rsv_addr=4 -> busy_vec[4]=1;
  - rd_b_addr=4 with rd_b_use=1 -> stall=1;
  - wb_en=1, wb_addr=4, wb_data=0x07E0 -> same cycle rd_b_busy=0, stall=0, rd_b_data=0x07E0;
  - next cycle busy_vec[4]=0.
- Simultaneous reserve and write-back to r6: rsv_addr=6 and wb_addr=6 with wb_data=0x1E0F in the same cycle -> reg6=0x1E0F and busy_vec[6]=1 afterwards.
- R0 hardwired: wb_en=1, wb_addr=0, wb_data=0xFFFF, plus rsv_addr=0 -> rd_a_addr=0 reads 0x0000, busy_vec[0]=0, stall=0.
- Reset mid-operation: with r1=0x15F3 and busy[1]=1, assert rst together with wb_en=1, wb_addr=1, wb_data=0x3333 -> next cycle r1=0x0000 and busy_vec=0.
